// File: rtl/trap_control_pkg.sv
// Shared constants and types for the privileged trap/redirect path.
package trap_control_pkg;

  localparam logic [1:0] MACHINE    = 2'b11;
  localparam logic [1:0] SUPERVISOR = 2'b01;
  localparam logic [1:0] USER       = 2'b00;

  localparam logic [11:0] CSR_SSTATUS = 12'h100;
  localparam logic [11:0] CSR_STVEC   = 12'h105;
  localparam logic [11:0] CSR_SEPC    = 12'h141;
  localparam logic [11:0] CSR_SCAUSE  = 12'h142;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEDELEG = 12'h302;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam logic [3:0] IRQ_MSI = 4'd3;
  localparam logic [3:0] IRQ_MTI = 4'd7;
  localparam logic [3:0] IRQ_MEI = 4'd11;

  typedef enum logic [2:0] {EV_NONE, EV_EXC, EV_INT, EV_MRET, EV_SRET} event_e;
  typedef enum logic [1:0] {ST_IDLE, ST_REDIRECT, ST_FLUSH} state_e;

endpackage

// File: rtl/trap_cause_select.sv
// Picks the single event to act on this cycle and where an exception lands.
module trap_cause_select
  import trap_control_pkg::*;
(
  input  logic        exception,
  input  logic [3:0]  exception_code,
  input  logic        m_ret,
  input  logic        s_ret,
  input  logic        m_ext_irq,
  input  logic        m_timer_irq,
  input  logic        m_soft_irq,
  input  logic        meie,
  input  logic        mtie,
  input  logic        msie,
  input  logic        m_ie,
  input  logic [1:0]  priv,
  input  logic [15:0] medeleg,
  output event_e      event_sel,
  output logic [3:0]  cause_code,
  output logic        to_supervisor
);

  logic irq_en, ext_ok, soft_ok, timer_ok;

  always_comb begin
    irq_en   = (priv != MACHINE) || m_ie;
    ext_ok   = irq_en && meie && m_ext_irq;
    soft_ok  = irq_en && msie && m_soft_irq;
    timer_ok = irq_en && mtie && m_timer_irq;

    event_sel     = EV_NONE;
    cause_code    = exception_code;
    to_supervisor = 1'b0;
    if (exception) begin
      event_sel     = EV_EXC;
      to_supervisor = medeleg[exception_code] && (priv <= SUPERVISOR);
    end else if (ext_ok) begin
      event_sel  = EV_INT;
      cause_code = IRQ_MEI;
    end else if (soft_ok) begin
      event_sel  = EV_INT;
      cause_code = IRQ_MSI;
    end else if (timer_ok) begin
      event_sel  = EV_INT;
      cause_code = IRQ_MTI;
    end else if (m_ret && priv == MACHINE) begin
      event_sel = EV_MRET;
    end else if (s_ret) begin
      event_sel = EV_SRET;
    end
  end

endmodule

// File: rtl/trap_control.sv
// Owns privilege level and M/S trap CSRs; issues one redirect pulse per event,
// then ignores new events until the pipeline has flushed.
module trap_control
  import trap_control_pkg::*;
#(
  parameter int          CORE            = 0,
  parameter int          ADDRESS_BITS    = 20,
  parameter logic [31:0] TRAP_VECTOR     = 32'h0,
  parameter int          FLUSH_CYCLES    = 3,
  parameter int          SCAN_CYCLES_MIN = 0,
  parameter int          SCAN_CYCLES_MAX = 1000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    exception,
  input  logic [3:0]              exception_code,
  input  logic [ADDRESS_BITS-1:0] trap_PC,
  input  logic                    m_ret,
  input  logic                    s_ret,
  input  logic                    m_ext_irq,
  input  logic                    m_timer_irq,
  input  logic                    m_soft_irq,
  input  logic                    csr_write_en,
  input  logic [11:0]             csr_address,
  input  logic [31:0]             csr_write_data,
  output logic [31:0]             csr_read_data,
  output logic [1:0]              priv,
  output logic                    trap_branch,
  output logic                    intr_branch,
  output logic                    eret_branch,
  output logic [ADDRESS_BITS-1:0] branch_target,
  input  logic                    scan
);

  localparam int          CNT_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [31:0] TVEC_RST = {TRAP_VECTOR[31:2], 1'b0, TRAP_VECTOR[0]};

  state_e                  state;
  logic [CNT_W-1:0]        flush_cnt;
  logic                    m_ie, m_pie, s_ie, s_pie, s_pp;
  logic [1:0]              m_pp;
  logic [15:0]             medeleg;
  logic                    meie, mtie, msie;
  logic [31:0]             mtvec, stvec;
  logic [ADDRESS_BITS-1:0] mepc, sepc;
  logic                    mcause_intr;
  logic [3:0]              mcause_code, scause_code;

  event_e      ev;
  logic [3:0]  cause_code;
  logic        to_s;
  logic [31:0] tvec_sel, tvec_base, trap_target;

  // Scan printout is a simulation aid only and has no hardware behaviour here.
  logic unused_inputs;
  assign unused_inputs = scan ^ (^csr_write_data) ^ (SCAN_CYCLES_MAX < SCAN_CYCLES_MIN) ^ (CORE < 0);

  trap_cause_select u_sel (
    .exception      (exception),
    .exception_code (exception_code),
    .m_ret          (m_ret),
    .s_ret          (s_ret),
    .m_ext_irq      (m_ext_irq),
    .m_timer_irq    (m_timer_irq),
    .m_soft_irq     (m_soft_irq),
    .meie           (meie),
    .mtie           (mtie),
    .msie           (msie),
    .m_ie           (m_ie),
    .priv           (priv),
    .medeleg        (medeleg),
    .event_sel      (ev),
    .cause_code     (cause_code),
    .to_supervisor  (to_s)
  );

  // Vectored mode only offsets interrupts; exceptions always use the base.
  always_comb begin
    tvec_sel    = to_s ? stvec : mtvec;
    tvec_base   = {tvec_sel[31:2], 2'b00};
    trap_target = (ev == EV_INT && tvec_sel[0]) ? tvec_base + {26'd0, cause_code, 2'b00}
                                                : tvec_base;
  end

  always_comb begin
    csr_read_data = '0;
    case (csr_address)
      CSR_MSTATUS: begin
        csr_read_data[1]     = s_ie;
        csr_read_data[3]     = m_ie;
        csr_read_data[5]     = s_pie;
        csr_read_data[7]     = m_pie;
        csr_read_data[8]     = s_pp;
        csr_read_data[12:11] = m_pp;
      end
      CSR_SSTATUS: begin
        csr_read_data[1] = s_ie;
        csr_read_data[5] = s_pie;
        csr_read_data[8] = s_pp;
      end
      CSR_MEDELEG: csr_read_data[15:0] = medeleg;
      CSR_MIE: begin
        csr_read_data[3]  = msie;
        csr_read_data[7]  = mtie;
        csr_read_data[11] = meie;
      end
      CSR_MIP: begin
        csr_read_data[3]  = m_soft_irq;
        csr_read_data[7]  = m_timer_irq;
        csr_read_data[11] = m_ext_irq;
      end
      CSR_MTVEC:  csr_read_data = mtvec;
      CSR_STVEC:  csr_read_data = stvec;
      CSR_MEPC:   csr_read_data = 32'(mepc);
      CSR_SEPC:   csr_read_data = 32'(sepc);
      CSR_MCAUSE: csr_read_data = {mcause_intr, 27'd0, mcause_code};
      CSR_SCAUSE: csr_read_data = {28'd0, scause_code};
      default:    csr_read_data = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      flush_cnt     <= '0;
      priv          <= MACHINE;
      m_ie          <= 1'b0;
      m_pie         <= 1'b0;
      m_pp          <= USER;
      s_ie          <= 1'b0;
      s_pie         <= 1'b0;
      s_pp          <= 1'b0;
      medeleg       <= '0;
      meie          <= 1'b0;
      mtie          <= 1'b0;
      msie          <= 1'b0;
      mtvec         <= TVEC_RST;
      stvec         <= TVEC_RST;
      mepc          <= '0;
      sepc          <= '0;
      mcause_intr   <= 1'b0;
      mcause_code   <= '0;
      scause_code   <= '0;
      trap_branch   <= 1'b0;
      intr_branch   <= 1'b0;
      eret_branch   <= 1'b0;
      branch_target <= '0;
    end else begin
      trap_branch <= 1'b0;
      intr_branch <= 1'b0;
      eret_branch <= 1'b0;

      // CSR write goes first so that event updates below override shared fields.
      if (csr_write_en) begin
        case (csr_address)
          CSR_MSTATUS: begin
            s_ie  <= csr_write_data[1];
            m_ie  <= csr_write_data[3];
            s_pie <= csr_write_data[5];
            m_pie <= csr_write_data[7];
            s_pp  <= csr_write_data[8];
            m_pp  <= csr_write_data[12:11];
          end
          CSR_SSTATUS: begin
            s_ie  <= csr_write_data[1];
            s_pie <= csr_write_data[5];
            s_pp  <= csr_write_data[8];
          end
          CSR_MEDELEG: medeleg <= csr_write_data[15:0];
          CSR_MIE: begin
            msie <= csr_write_data[3];
            mtie <= csr_write_data[7];
            meie <= csr_write_data[11];
          end
          CSR_MTVEC:  mtvec <= {csr_write_data[31:2], 1'b0, csr_write_data[0]};
          CSR_STVEC:  stvec <= {csr_write_data[31:2], 1'b0, csr_write_data[0]};
          CSR_MEPC:   mepc  <= {csr_write_data[ADDRESS_BITS-1:1], 1'b0};
          CSR_SEPC:   sepc  <= {csr_write_data[ADDRESS_BITS-1:1], 1'b0};
          CSR_MCAUSE: begin
            mcause_intr <= csr_write_data[31];
            mcause_code <= csr_write_data[3:0];
          end
          CSR_SCAUSE: scause_code <= csr_write_data[3:0];
          default: ;
        endcase
      end

      case (state)
        ST_IDLE: begin
          if (ev != EV_NONE) begin
            state <= ST_REDIRECT;
            case (ev)
              EV_EXC, EV_INT: begin
                trap_branch   <= (ev == EV_EXC);
                intr_branch   <= (ev == EV_INT);
                branch_target <= trap_target[ADDRESS_BITS-1:0];
                if (to_s) begin
                  sepc        <= {trap_PC[ADDRESS_BITS-1:1], 1'b0};
                  scause_code <= cause_code;
                  s_pie       <= s_ie;
                  s_ie        <= 1'b0;
                  s_pp        <= priv[0];
                  priv        <= SUPERVISOR;
                end else begin
                  mepc        <= {trap_PC[ADDRESS_BITS-1:1], 1'b0};
                  mcause_intr <= (ev == EV_INT);
                  mcause_code <= cause_code;
                  m_pie       <= m_ie;
                  m_ie        <= 1'b0;
                  m_pp        <= priv;
                  priv        <= MACHINE;
                end
              end
              EV_MRET: begin
                eret_branch   <= 1'b1;
                branch_target <= mepc;
                priv          <= m_pp;
                m_ie          <= m_pie;
                m_pie         <= 1'b1;
                m_pp          <= USER;
              end
              EV_SRET: begin
                eret_branch   <= 1'b1;
                branch_target <= sepc;
                priv          <= {1'b0, s_pp};
                s_ie          <= s_pie;
                s_pie         <= 1'b1;
                s_pp          <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        ST_REDIRECT: begin
          if (FLUSH_CYCLES <= 1) begin
            state <= ST_IDLE;
          end else begin
            state     <= ST_FLUSH;
            flush_cnt <= CNT_W'(1);
          end
        end
        ST_FLUSH: begin
          if (flush_cnt == CNT_LAST) state <= ST_IDLE;
          else flush_cnt <= flush_cnt + CNT_W'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
